// File: rtl/gpio_pattern_sequencer.sv
// rtl/gpio_pattern_sequencer.sv - timed GPIO diagnostic pattern sequencer
module gpio_pattern_sequencer #(
  parameter int NUM_PINS    = 32,
  parameter int STEP_CYCLES = 3_000_000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                stop,
  input  logic [1:0]          mode,
  input  logic                loop,
  output logic [NUM_PINS-1:0] gpio_o,
  output logic                busy,
  output logic [4:0]          step_idx,
  output logic                step_strobe,
  output logic                pass_done
);

  // Prescaler keeps at least one bit so STEP_CYCLES=1 still elaborates.
  localparam int PW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(STEP_CYCLES - 1);
  localparam logic [4:0]    IDX_LAST   = 5'(NUM_PINS - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                state_q, state_n;
  logic [PW-1:0]         presc_q, presc_n;
  logic [4:0]            idx_n;
  logic [NUM_PINS-1:0]   count_q, count_n;
  logic [1:0]            mode_q, mode_n;
  logic                  loop_q, loop_n;
  logic                  advance, wrap, finish;
  logic [NUM_PINS-1:0]   gpio_n;
  logic                  busy_n, strobe_n, pass_n;

  // Pattern for step k; the count register carries the binary-count value.
  function automatic logic [NUM_PINS-1:0] pattern(input logic [1:0] m,
                                                  input logic [4:0] k,
                                                  input logic [NUM_PINS-1:0] cnt);
    logic [NUM_PINS-1:0] one_hot;
    logic [NUM_PINS-1:0] checker_pat;
    logic [NUM_PINS-1:0] res;
    one_hot = {{(NUM_PINS-1){1'b0}}, 1'b1} << k;
    for (int i = 0; i < NUM_PINS; i++) begin
      checker_pat[i] = (i % 2 == 0) ? ~k[0] : k[0];
    end
    case (m)
      2'd0:    res = one_hot;
      2'd1:    res = ~one_hot;
      2'd2:    res = cnt;
      default: res = checker_pat;
    endcase
    return res;
  endfunction

  // State and datapath registers, outputs registered alongside.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      presc_q     <= '0;
      step_idx    <= '0;
      count_q     <= '0;
      mode_q      <= '0;
      loop_q      <= 1'b0;
      gpio_o      <= '0;
      busy        <= 1'b0;
      step_strobe <= 1'b0;
      pass_done   <= 1'b0;
    end else begin
      state_q     <= state_n;
      presc_q     <= presc_n;
      step_idx    <= idx_n;
      count_q     <= count_n;
      mode_q      <= mode_n;
      loop_q      <= loop_n;
      gpio_o      <= gpio_n;
      busy        <= busy_n;
      step_strobe <= strobe_n;
      pass_done   <= pass_n;
    end
  end

  // Next state: start acceptance, dwell prescaler, step and pass sequencing.
  always_comb begin
    state_n = state_q;
    presc_n = presc_q;
    idx_n   = step_idx;
    count_n = count_q;
    mode_n  = mode_q;
    loop_n  = loop_q;
    advance = 1'b0;
    wrap    = 1'b0;
    finish  = 1'b0;
    if (stop) begin
      state_n = IDLE;
      presc_n = '0;
      idx_n   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_n = RUN;
            mode_n  = mode;
            loop_n  = loop;
            presc_n = '0;
            idx_n   = '0;
            count_n = '0;
          end
        end
        default: begin
          if (presc_q == PRESC_LAST) begin
            presc_n = '0;
            count_n = count_q + NUM_PINS'(1);
            if (step_idx == IDX_LAST) begin
              idx_n = '0;
              if (loop_q) begin
                wrap = 1'b1;
              end else begin
                state_n = IDLE;
                finish  = 1'b1;
              end
            end else begin
              idx_n   = step_idx + 5'd1;
              advance = 1'b1;
            end
          end else begin
            presc_n = presc_q + PW'(1);
          end
        end
      endcase
    end
  end

  // Output values to be registered for the next cycle.
  always_comb begin
    gpio_n   = '0;
    busy_n   = 1'b0;
    strobe_n = advance | wrap;
    pass_n   = wrap | finish;
    if (state_n == RUN) begin
      gpio_n = pattern(mode_n, idx_n, count_n);
      busy_n = 1'b1;
    end
  end

endmodule
